// File: rtl/csr_file.sv
// Machine-mode CSR file for the RV32I core: CSR access, privilege mode, traps, MRET
// and the 64-bit cycle/instret counters.
module csr_file #(
  parameter logic [31:0] HART_ID    = 32'd0,
  parameter logic [31:0] MISA_VALUE = 32'h4000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        csr_access,
  input  logic [1:0]  csr_operation,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  input  logic        csr_wr_suppress,
  input  logic        instr_retire,
  input  logic        trap_req,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic        mret,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  output logic [31:0] trap_vector,
  output logic [31:0] epc,
  output logic [1:0]  priv_mode
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MISA      = 12'h301;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_INSTRETH  = 12'hC82;
  localparam logic [11:0] A_MHARTID   = 12'hF14;

  localparam logic [1:0] PRIV_M = 2'b11;
  localparam logic [1:0] PRIV_U = 2'b00;

  logic [1:0]  priv_r;
  logic        mie_r;
  logic        mpie_r;
  logic [1:0]  mpp_r;
  logic [31:0] mtvec_r;
  logic [31:0] mscratch_r;
  logic [31:0] mepc_r;
  logic [31:0] mcause_r;
  logic [63:0] mcycle_r;
  logic [63:0] minstret_r;

  logic [31:0] mstatus_s;
  logic [31:0] old_s;
  logic [31:0] new_s;
  logic        impl_s;
  logic        writes_s;
  logic        acc_illegal_s;
  logic        mret_ok_s;
  logic        csr_we_s;

  // MPP only holds M or U; any other written encoding collapses to U.
  function automatic logic [1:0] mpp_legalize(input logic [1:0] v);
    return (v == PRIV_M) ? PRIV_M : PRIV_U;
  endfunction

  assign mstatus_s = {19'd0, mpp_r, 3'd0, mpie_r, 3'd0, mie_r, 3'd0};

  // Address decode: current value of the addressed CSR and whether it exists.
  always_comb begin
    old_s  = 32'd0;
    impl_s = 1'b1;
    case (csr_addr)
      A_MSTATUS:               old_s = mstatus_s;
      A_MISA:                  old_s = MISA_VALUE;
      A_MTVEC:                 old_s = mtvec_r;
      A_MSCRATCH:              old_s = mscratch_r;
      A_MEPC:                  old_s = mepc_r;
      A_MCAUSE:                old_s = mcause_r;
      A_MCYCLE,    A_CYCLE:    old_s = mcycle_r[31:0];
      A_MCYCLEH,   A_CYCLEH:   old_s = mcycle_r[63:32];
      A_MINSTRET,  A_INSTRET:  old_s = minstret_r[31:0];
      A_MINSTRETH, A_INSTRETH: old_s = minstret_r[63:32];
      A_MHARTID:               old_s = HART_ID;
      default: begin
        old_s  = 32'd0;
        impl_s = 1'b0;
      end
    endcase
  end

  // Write value by operation and the legality / priority qualifiers.
  always_comb begin
    case (csr_operation)
      2'b01:   new_s = csr_wdata;
      2'b10:   new_s = old_s | csr_wdata;
      2'b11:   new_s = old_s & ~csr_wdata;
      default: new_s = old_s;
    endcase
    writes_s      = (csr_operation != 2'b00) && !csr_wr_suppress;
    acc_illegal_s = csr_access &&
                    (!impl_s || (priv_r < csr_addr[9:8]) ||
                     (writes_s && (csr_addr[11:10] == 2'b11)));
    mret_ok_s     = mret && (priv_r == PRIV_M) && !trap_req;
    // Any trap or MRET in the same cycle drops the CSR write.
    csr_we_s      = csr_access && writes_s && !acc_illegal_s && !trap_req && !mret;
  end

  assign csr_rdata   = csr_access ? old_s : 32'd0;
  assign csr_illegal = acc_illegal_s || (mret && (priv_r != PRIV_M));
  assign trap_vector = {mtvec_r[31:2], 2'b00};
  assign epc         = mepc_r;
  assign priv_mode   = priv_r;

  // Architectural state: counters, then trap > MRET > CSR write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      priv_r     <= PRIV_M;
      mie_r      <= 1'b0;
      mpie_r     <= 1'b0;
      mpp_r      <= 2'b00;
      mtvec_r    <= 32'd0;
      mscratch_r <= 32'd0;
      mepc_r     <= 32'd0;
      mcause_r   <= 32'd0;
      mcycle_r   <= 64'd0;
      minstret_r <= 64'd0;
    end else begin
      mcycle_r <= mcycle_r + 64'd1;
      if (instr_retire && !trap_req) begin
        minstret_r <= minstret_r + 64'd1;
      end else begin
        minstret_r <= minstret_r;
      end

      if (trap_req) begin
        mepc_r   <= trap_pc & ~32'd3;
        mcause_r <= trap_cause;
        mpie_r   <= mie_r;
        mie_r    <= 1'b0;
        mpp_r    <= mpp_legalize(priv_r);
        priv_r   <= PRIV_M;
      end else if (mret_ok_s) begin
        priv_r <= mpp_r;
        mie_r  <= mpie_r;
        mpie_r <= 1'b1;
        mpp_r  <= PRIV_U;
      end else if (csr_we_s) begin
        // Counter writes below override the increment scheduled above.
        case (csr_addr)
          A_MSTATUS: begin
            mie_r  <= new_s[3];
            mpie_r <= new_s[7];
            mpp_r  <= mpp_legalize(new_s[12:11]);
          end
          A_MTVEC:     mtvec_r    <= {new_s[31:2], 2'b00};
          A_MSCRATCH:  mscratch_r <= new_s;
          A_MEPC:      mepc_r     <= {new_s[31:2], 2'b00};
          A_MCAUSE:    mcause_r   <= new_s;
          A_MCYCLE:    mcycle_r   <= {mcycle_r[63:32], new_s};
          A_MCYCLEH:   mcycle_r   <= {new_s, mcycle_r[31:0]};
          A_MINSTRET:  minstret_r <= {minstret_r[63:32], new_s};
          A_MINSTRETH: minstret_r <= {new_s, minstret_r[31:0]};
          default: ;
        endcase
      end else begin
        priv_r <= priv_r;
      end
    end
  end

endmodule

// File: tb/tb_csr_file.sv
// Directed scoreboard bench for csr_file: stimulus pushes expectations, a negedge
// monitor pops and compares whenever a checked vector is on the inputs.
module tb_csr_file;

  localparam logic [31:0] MISA = 32'h4000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        csr_access;
  logic [1:0]  csr_operation;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        csr_wr_suppress;
  logic        instr_retire;
  logic        trap_req;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic        mret;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic [31:0] trap_vector;
  logic [31:0] epc;
  logic [1:0]  priv_mode;

  csr_file #(.HART_ID(32'd0), .MISA_VALUE(MISA)) dut (
    .clk(clk), .rst_n(rst_n), .csr_access(csr_access), .csr_operation(csr_operation),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_wr_suppress(csr_wr_suppress),
    .instr_retire(instr_retire), .trap_req(trap_req), .trap_cause(trap_cause),
    .trap_pc(trap_pc), .mret(mret), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .trap_vector(trap_vector), .epc(epc), .priv_mode(priv_mode)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        rd_chk;
    logic        ill;
    logic [1:0]  priv;
    logic [31:0] epc;
    logic [31:0] tvec;
  } exp_t;

  exp_t        q[$];
  logic        chk = 1'b0;
  int          nvec = 0;
  int          nfail = 0;
  logic [1:0]  e_priv = 2'b11;
  logic [31:0] e_epc = 32'd0;
  logic [31:0] e_tvec = 32'd0;

  task automatic idle();
    csr_access = 1'b0; csr_operation = 2'b00; csr_addr = 12'h000; csr_wdata = 32'd0;
    csr_wr_suppress = 1'b0; instr_retire = 1'b0; trap_req = 1'b0;
    trap_cause = 32'd0; trap_pc = 32'd0; mret = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Drive one cycle of stimulus (side controls set by caller) and queue its expectation.
  task automatic step(input logic acc, input logic [1:0] op, input logic [11:0] addr,
                      input logic [31:0] wd, input logic rdc, input logic [31:0] er,
                      input logic ei);
    exp_t e;
    csr_access = acc; csr_operation = op; csr_addr = addr; csr_wdata = wd;
    e = '{er, rdc, ei, e_priv, e_epc, e_tvec};
    q.push_back(e);
    chk = 1'b1;
    @(posedge clk); #1;
    chk = 1'b0;
    idle();
  endtask

  task automatic rd(input logic [11:0] addr, input logic [31:0] er);
    step(1'b1, 2'b00, addr, 32'd0, 1'b1, er, 1'b0);
  endtask

  // Monitor: compare whenever a checked vector is presented.
  always @(negedge clk) begin
    if (chk) begin
      exp_t e;
      nvec++;
      if (q.size() == 0) begin
        nfail++;
        $display("FAIL scoreboard_empty t=%0t: no expectation queued", $time);
      end else begin
        e = q.pop_front();
        if ((e.rd_chk && (csr_rdata !== e.rdata)) || (csr_illegal !== e.ill) ||
            (priv_mode !== e.priv) || (epc !== e.epc) || (trap_vector !== e.tvec)) begin
          nfail++;
          $display("FAIL vec%0d addr=%h: rdata=%h ill=%b priv=%b epc=%h tvec=%h required rdata=%h(chk%b) ill=%b priv=%b epc=%h tvec=%h",
                   nvec, csr_addr, csr_rdata, csr_illegal, priv_mode, epc, trap_vector,
                   e.rdata, e.rd_chk, e.ill, e.priv, e.epc, e.tvec);
        end
      end
    end
  end

  initial begin
    idle();
    rst_n = 1'b0;
    tick();
    step(1'b0, 2'b00, 12'h000, 32'd0, 1'b1, 32'd0, 1'b0);   // held in reset
    rst_n = 1'b1;
    tick();
    rd(12'hB00, 32'd1);
    rd(12'h300, 32'd0);
    rd(12'h305, 32'd0);

    // mstatus write / set / clear and MPP legalization
    step(1'b1, 2'b01, 12'h300, 32'h1888, 1'b1, 32'h0, 1'b0);
    rd(12'h300, 32'h1888);
    step(1'b1, 2'b10, 12'h300, 32'h8, 1'b1, 32'h1888, 1'b0);
    rd(12'h300, 32'h1888);
    step(1'b1, 2'b11, 12'h300, 32'h8, 1'b1, 32'h1888, 1'b0);
    rd(12'h300, 32'h1880);
    step(1'b1, 2'b01, 12'h300, 32'h0808, 1'b1, 32'h1880, 1'b0);
    rd(12'h300, 32'h0008);

    // trap then MRET (MPP=11 keeps M)
    trap_req = 1'b1; trap_cause = 32'd11; trap_pc = 32'h1006;
    step(1'b0, 2'b00, 12'h000, 32'd0, 1'b1, 32'd0, 1'b0);
    e_epc = 32'h1004;
    rd(12'h341, 32'h1004);
    rd(12'h342, 32'd11);
    rd(12'h300, 32'h1880);
    mret = 1'b1;
    step(1'b0, 2'b00, 12'h000, 32'd0, 1'b1, 32'd0, 1'b0);
    rd(12'h300, 32'h0088);

    // read-only / unimplemented / masked registers
    rd(12'h301, MISA);
    rd(12'hF14, 32'd0);
    step(1'b1, 2'b00, 12'h123, 32'd0, 1'b1, 32'd0, 1'b1);
    step(1'b1, 2'b01, 12'hF14, 32'd1, 1'b1, 32'd0, 1'b1);
    step(1'b1, 2'b01, 12'h301, 32'd0, 1'b1, MISA, 1'b0);
    rd(12'h301, MISA);
    step(1'b1, 2'b01, 12'h305, 32'h1003, 1'b1, 32'd0, 1'b0);
    e_tvec = 32'h1000;
    rd(12'h305, 32'h1000);
    csr_wr_suppress = 1'b1;
    step(1'b1, 2'b10, 12'hF14, 32'hFFFF, 1'b1, 32'd0, 1'b0);
    step(1'b1, 2'b01, 12'h341, 32'h5557, 1'b1, 32'h1004, 1'b0);
    e_epc = 32'h5554;
    rd(12'h341, 32'h5554);

    // counters: carry into high word, write beats increment
    step(1'b1, 2'b01, 12'hB80, 32'd0, 1'b0, 32'd0, 1'b0);
    step(1'b1, 2'b01, 12'hB00, 32'hFFFF_FFFF, 1'b0, 32'd0, 1'b0);
    rd(12'hB00, 32'hFFFF_FFFF);
    rd(12'hB80, 32'd1);
    rd(12'hB00, 32'd1);
    rd(12'hC80, 32'd1);
    instr_retire = 1'b1;
    step(1'b1, 2'b01, 12'hB02, 32'd5, 1'b0, 32'd0, 1'b0);
    instr_retire = 1'b1;
    rd(12'hB02, 32'd5);
    rd(12'hC02, 32'd6);

    // trap beats MRET beats CSR write
    step(1'b1, 2'b01, 12'h340, 32'hAAAA_5555, 1'b1, 32'd0, 1'b0);
    rd(12'h340, 32'hAAAA_5555);
    trap_req = 1'b1; trap_cause = 32'd2; trap_pc = 32'h2000; mret = 1'b1; instr_retire = 1'b1;
    step(1'b1, 2'b01, 12'h340, 32'h1234, 1'b1, 32'hAAAA_5555, 1'b0);
    e_epc = 32'h2000;
    rd(12'h340, 32'hAAAA_5555);
    rd(12'hB02, 32'd6);
    rd(12'h342, 32'd2);
    rd(12'h300, 32'h1880);

    // drop to U mode and probe privilege checks
    step(1'b1, 2'b01, 12'h300, 32'd0, 1'b1, 32'h1880, 1'b0);
    mret = 1'b1;
    step(1'b0, 2'b00, 12'h000, 32'd0, 1'b1, 32'd0, 1'b0);
    e_priv = 2'b00;
    step(1'b1, 2'b00, 12'h300, 32'd0, 1'b0, 32'd0, 1'b1);
    step(1'b1, 2'b00, 12'hC00, 32'd0, 1'b0, 32'd0, 1'b0);
    step(1'b1, 2'b01, 12'hC00, 32'd0, 1'b0, 32'd0, 1'b1);
    mret = 1'b1;
    step(1'b0, 2'b00, 12'h000, 32'd0, 1'b1, 32'd0, 1'b1);
    step(1'b1, 2'b01, 12'h340, 32'd0, 1'b0, 32'd0, 1'b1);
    step(1'b1, 2'b00, 12'hC82, 32'd0, 1'b1, 32'd0, 1'b0);
    trap_req = 1'b1; trap_cause = 32'd8; trap_pc = 32'h3000;
    step(1'b0, 2'b00, 12'h000, 32'd0, 1'b1, 32'd0, 1'b0);
    e_priv = 2'b11; e_epc = 32'h3000;
    rd(12'h340, 32'hAAAA_5555);
    rd(12'h300, 32'h0000);
    rd(12'h342, 32'd8);

    // reset mid-operation discards the pending write
    e_epc = 32'd0; e_tvec = 32'd0;
    rst_n = 1'b0;
    step(1'b1, 2'b01, 12'h340, 32'd1, 1'b1, 32'd0, 1'b0);
    rst_n = 1'b1;
    rd(12'hB00, 32'd0);
    rd(12'h340, 32'd0);
    rd(12'h305, 32'd0);

    tick();
    tick();
    if (q.size() != 0) begin
      nfail++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
